ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: sync + glitch filter, 11-bit frame decode, E0/F0 prefix folding.
// Raw stop-bit fall to valid is 2 sync + FILT + 2 clk cycles; no backpressure, valid/err are 1-cycle pulses.
module ps2_frame_rx #(
  parameter int FILT        = 8,
  parameter int TIMEOUT_CYC = 14318
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic          clk_prev_q, clk_prev_d, fall_q, fall_d;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d, brk_q, brk_d, valid_q, valid_d, err_q, err_d;

  // Filtered level only flips after the synchronized level disagrees for FILT straight cycles.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FW'(FILT - 1)) clk_filt_d = clk_sync_q[1];
      else                            clk_cnt_d  = clk_cnt_q + 1'b1;
    end
    dat_filt_d = dat_filt_q;
    dat_cnt_d  = '0;
    if (dat_sync_q[1] != dat_filt_q) begin
      if (dat_cnt_q == FW'(FILT - 1)) dat_filt_d = dat_sync_q[1];
      else                            dat_cnt_d  = dat_cnt_q + 1'b1;
    end
    clk_prev_d = clk_filt_q;
    fall_d     = clk_prev_q & ~clk_filt_q;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    to_cnt_d   = '0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_q) begin
          if (!dat_filt_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d   = {dat_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_d   = dat_filt_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && dat_filt_q) begin
            if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d     = shift_q;
              ext_d      = ext_pend_q;
              brk_d      = brk_pend_q;
              valid_d    = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall in the expiry cycle restarts the count instead of timing out.
    if (state_q != IDLE) begin
      if (fall_q) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d     = 1'b1;
        state_d   = IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (err_d) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign code  = code_q;
  assign ext   = ext_q;
  assign brk   = brk_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: keyboard-side frame driver, negedge pulse monitor, one task per scenario.
module tb_ps2_frame_rx;

  localparam int T_OUT = 14318;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       ext, brk, valid, err, busy;

  ps2_frame_rx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .ext      (ext),
    .brk      (brk),
    .valid    (valid),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int half_per = 40;
  int pass_cnt = 0, chk_cnt = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, busy_cnt = 0;
  int valid_cyc = 0, err_cyc = 0, last_fall_cyc = 0;
  logic prev_valid = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if (valid) begin valid_cnt++; valid_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (valid && err) both_cnt++;
    if ((valid && prev_valid) || (err && prev_err)) long_cnt++;
    if (busy) busy_cnt++;
    prev_valid = valid;
    prev_err   = err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(half_per);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    tick(half_per);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ par_flip);
    send_bit(stop_b);
    ps2_data = 1'b1;
    tick(4 * half_per);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    chk_cnt++; if (code !== 8'h00) $display("FAIL reset_code: got %h want 00", code); else pass_cnt++;
    chk_cnt++; if ({ext, brk, valid, err, busy} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {ext, brk, valid, err, busy}); else pass_cnt++;
    reset_n = 1'b1;
    tick(20);
    chk_cnt++; if (busy !== 1'b0 || err_cnt != 0) $display("FAIL reset_idle: busy %b errs %0d want 0 0", busy, err_cnt); else pass_cnt++;
  endtask

  task automatic test_basic_slow();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    half_per = 573;
    send_frame(8'h1C, 1'b0, 1'b1);
    half_per = 40;
    chk_cnt++; if (valid_cnt - v0 != 1) $display("FAIL basic_valid_count: got %0d want 1", valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if ({code, ext, brk} !== {8'h1C, 2'b00}) $display("FAIL basic_code: got %h/%b%b want 1c/00", code, ext, brk); else pass_cnt++;
    chk_cnt++; if (err_cnt != e0) $display("FAIL basic_no_err: got %0d errs want 0", err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (valid_cyc - last_fall_cyc != 12) $display("FAIL basic_latency: got %0d want 12", valid_cyc - last_fall_cyc); else pass_cnt++;
  endtask

  task automatic test_break();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    chk_cnt++; if (valid_cnt != v0) $display("FAIL brk_prefix_silent: got %0d valids want 0", valid_cnt - v0); else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_cnt++; if (valid_cnt - v0 != 1) $display("FAIL brk_valid_count: got %0d want 1", valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if ({code, ext, brk} !== {8'h1C, 2'b01}) $display("FAIL brk_code: got %h/%b%b want 1c/01", code, ext, brk); else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_cnt++; if ({code, ext, brk} !== {8'h1C, 2'b00}) $display("FAIL brk_cleared: got %h/%b%b want 1c/00", code, ext, brk); else pass_cnt++;
  endtask

  task automatic test_ext_break();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk_cnt++; if (valid_cnt - v0 != 1) $display("FAIL extbrk_valid_count: got %0d want 1", valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if ({code, ext, brk} !== {8'h75, 2'b11}) $display("FAIL extbrk_code: got %h/%b%b want 75/11", code, ext, brk); else pass_cnt++;
    send_frame(8'h75, 1'b0, 1'b1);
    chk_cnt++; if ({code, ext, brk} !== {8'h75, 2'b00}) $display("FAIL extbrk_cleared: got %h/%b%b want 75/00", code, ext, brk); else pass_cnt++;
    send_frame(8'hAA, 1'b0, 1'b1);
    chk_cnt++; if ({code, ext, brk} !== {8'hAA, 2'b00} || valid_cnt - v0 != 3) $display("FAIL aa_code: got %h/%b%b n%0d want aa/00 n3", code, ext, brk, valid_cnt - v0); else pass_cnt++;
  endtask

  task automatic test_frame_errors();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    chk_cnt++; if (err_cnt - e0 != 1 || valid_cnt != v0) $display("FAIL parity_err: got err %0d valid %0d want 1 0", err_cnt - e0, valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL parity_busy: got %b want 0", busy); else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_cnt++; if (valid_cnt - v0 != 1 || code !== 8'h1C) $display("FAIL parity_recover: got %0d/%h want 1/1c", valid_cnt - v0, code); else pass_cnt++;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b0);
    chk_cnt++; if (err_cnt - e0 != 1 || valid_cnt != v0) $display("FAIL stop_err: got err %0d valid %0d want 1 0", err_cnt - e0, valid_cnt - v0); else pass_cnt++;
    e0 = err_cnt;
    send_bit(1'b1);
    tick(4 * half_per);
    chk_cnt++; if (err_cnt - e0 != 1 || busy !== 1'b0 || valid_cnt != v0) $display("FAIL start_err: got err %0d busy %b want 1 0", err_cnt - e0, busy); else pass_cnt++;
  endtask

  task automatic test_pend_kept();
    send_frame(8'hE0, 1'b0, 1'b1);
    tick(3000);
    send_frame(8'h75, 1'b0, 1'b1);
    chk_cnt++; if ({code, ext, brk} !== {8'h75, 2'b10}) $display("FAIL pend_kept: got %h/%b%b want 75/10", code, ext, brk); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    ps2_data = 1'b1;
    tick(20000);
    chk_cnt++; if (err_cnt - e0 != 1 || valid_cnt != v0) $display("FAIL timeout_err: got err %0d valid %0d want 1 0", err_cnt - e0, valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if (err_cyc - last_fall_cyc < T_OUT + 10 || err_cyc - last_fall_cyc > T_OUT + 14)
      $display("FAIL timeout_time: got %0d want %0d..%0d", err_cyc - last_fall_cyc, T_OUT + 10, T_OUT + 14); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy); else pass_cnt++;
    send_frame(8'h75, 1'b0, 1'b1);
    chk_cnt++; if ({code, ext, brk} !== {8'h75, 2'b00} || valid_cnt - v0 != 1) $display("FAIL timeout_ext_cleared: got %h/%b%b want 75/00", code, ext, brk); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int b0, e0;
    b0 = busy_cnt; e0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      tick(50);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
    end
    tick(50);
    chk_cnt++; if (busy_cnt != b0 || err_cnt != e0) $display("FAIL glitch: got busy %0d err %0d want 0 0", busy_cnt - b0, err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tick(10);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else pass_cnt++;
    v0 = valid_cnt; e0 = err_cnt;
    reset_n = 1'b0;
    tick(3);
    chk_cnt++; if ({code, ext, brk, valid, err, busy} !== 13'b0) $display("FAIL midrst_outputs: got %h/%b want 00/00000", code, {ext, brk, valid, err, busy}); else pass_cnt++;
    reset_n = 1'b1;
    ps2_data = 1'b1;
    tick(4 * half_per);
    chk_cnt++; if (valid_cnt != v0 || err_cnt != e0) $display("FAIL midrst_silent: got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0); else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_cnt++; if (valid_cnt - v0 != 1 || {code, ext, brk} !== {8'h1C, 2'b00}) $display("FAIL midrst_recover: got %0d %h want 1 1c", valid_cnt - v0, code); else pass_cnt++;
  endtask

  task automatic test_pulse_rules();
    chk_cnt++; if (both_cnt != 0) $display("FAIL valid_err_overlap: got %0d want 0", both_cnt); else pass_cnt++;
    chk_cnt++; if (long_cnt != 0) $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_slow();
    test_break();
    test_ext_break();
    test_frame_errors();
    test_pend_kept();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_pulse_rules();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
